// File: rtl/lut_stim_checker_pkg.sv
// Shared types and limits for the LUT stimulus/response checker.
package lut_stim_checker_pkg;

  localparam int unsigned WIDTH_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_e;

  // The settle counter must stay at least one bit wide, even when SETTLE == 1.
  function automatic int unsigned timer_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/lut_stim_checker_if.sv
// Control, status and DUT-facing signals of the checker.
// The slave side is the checker. The master side is whatever starts it and drives dut_o.
interface lut_stim_checker_if #(
  parameter int unsigned WIDTH = 1
);

  logic             start;
  logic [WIDTH-1:0] dut_i;
  logic             dut_o;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [WIDTH:0]   err_cnt;
  logic [WIDTH-1:0] first_fail;

  modport master (
    output start, dut_o,
    input  dut_i, busy, done, pass, fail, err_cnt, first_fail
  );

  modport slave (
    input  start, dut_o,
    output dut_i, busy, done, pass, fail, err_cnt, first_fail
  );

endinterface

// File: rtl/lut_stim_checker_timer.sv
// Loadable down-counter that paces the settle time of each vector.
module settle_timer
  import lut_stim_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned    CW     = timer_width(SETTLE);
  localparam logic [CW-1:0]  RELOAD = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lut_stim_checker.sv
// Walks every input vector of a small LUT DUT and waits a settle time before each sample.
// Compares each sample against TRUTH and keeps the error count and the first failing vector.
module lut_stim_checker
  import lut_stim_checker_pkg::*;
#(
  parameter int unsigned              WIDTH  = 1,
  parameter logic [(2**WIDTH)-1:0]    TRUTH  = 2'b01,
  parameter int unsigned              SETTLE = 4
) (
  input logic               clk,
  input logic               rst_n,
  lut_stim_checker_if.slave bus
);

  if ((WIDTH < 1) || (WIDTH > WIDTH_MAX) || (SETTLE < 1)) begin : g_param_err
    $error("lut_stim_checker: WIDTH must be 1..%0d and SETTLE >= 1", WIDTH_MAX);
  end

  localparam logic [WIDTH-1:0] LAST_VEC = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [WIDTH:0]   err_q, err_d;
  logic [WIDTH-1:0] ff_q, ff_d;
  logic             t_load, t_dec, t_zero;
  logic             done_w, fail_w;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (t_load),
    .dec   (t_dec),
    .zero  (t_zero)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ff_d    = ff_q;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = WAIT;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          t_load  = 1'b1;
        end
      end
      WAIT: begin
        if (t_zero) begin
          state_d = CHECK;
        end else begin
          t_dec = 1'b1;
        end
      end
      CHECK: begin
        if (bus.dut_o != TRUTH[vec_q]) begin
          err_d = err_q + (WIDTH + 1)'(1);
          // A zero count before this mismatch means it is the first one of the run.
          if (err_q == '0) begin
            ff_d = vec_q;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + WIDTH'(1);
          t_load  = 1'b1;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  // The vector index register drives the DUT directly, so dut_i is registered.
  assign done_w         = (state_q == DONE);
  assign fail_w         = done_w && (err_q != '0);
  assign bus.dut_i      = vec_q;
  assign bus.busy       = (state_q == WAIT) || (state_q == CHECK);
  assign bus.done       = done_w;
  assign bus.pass       = done_w && (err_q == '0);
  assign bus.fail       = fail_w;
  assign bus.err_cnt    = err_q;
  assign bus.first_fail = fail_w ? ff_q : '0;

endmodule

// File: tb/tb_lut_stim_checker.sv
// Bench for two checker configurations: the defaults (inverter truth table), and a
// 2-input AND truth table with a short settle time. The DUTs are modelled as lookup tables.
module tb_lut_stim_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lut_stim_checker_if #(.WIDTH(1)) bus_a ();
  lut_stim_checker_if #(.WIDTH(2)) bus_b ();

  lut_stim_checker #(.WIDTH(1), .TRUTH(2'b01), .SETTLE(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  lut_stim_checker #(.WIDTH(2), .TRUTH(4'b1000), .SETTLE(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Bit v of a model table gives the DUT output for input vector v.
  logic [1:0] model_a;
  logic [3:0] model_b;
  always_comb bus_a.dut_o = model_a[bus_a.dut_i];
  always_comb bus_b.dut_o = model_b[bus_b.dut_i];

  bit sel;
  logic [31:0] obs_dut_i, obs_err, obs_ff;
  logic        obs_busy, obs_done, obs_pass, obs_fail;
  always_comb begin
    obs_dut_i = sel ? 32'(bus_b.dut_i)      : 32'(bus_a.dut_i);
    obs_err   = sel ? 32'(bus_b.err_cnt)    : 32'(bus_a.err_cnt);
    obs_ff    = sel ? 32'(bus_b.first_fail) : 32'(bus_a.first_fail);
    obs_busy  = sel ? bus_b.busy : bus_a.busy;
    obs_done  = sel ? bus_b.done : bus_a.done;
    obs_pass  = sel ? bus_b.pass : bus_a.pass;
    obs_fail  = sel ? bus_b.fail : bus_a.fail;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) bus_b.start = v;
    else     bus_a.start = v;
  endtask

  // Reference result: count of vectors where the DUT table differs from TRUTH,
  // and the lowest such vector.
  function automatic void ref_model(input logic [15:0] dut_tt, input logic [15:0] truth,
                                    input int n, output int err, output int ff);
    err = 0;
    ff  = 0;
    for (int v = n - 1; v >= 0; v--) begin
      if (dut_tt[v] != truth[v]) begin
        err++;
        ff = v;
      end
    end
  endfunction

  // Runs one full check. Every cycle it checks dut_i, busy and done against the
  // per-vector SETTLE+1 cycle schedule, then checks the final result.
  // pulse_at >= 0 pulses start again that many cycles after acceptance.
  task automatic run_vec(input bit sel_in, input logic [3:0] model, input int exp_err,
                         input int exp_ff, input int pulse_at);
    int n, s, total, exp_vec;
    sel   = sel_in;
    n     = sel_in ? 4 : 2;
    s     = sel_in ? 2 : 4;
    total = n * (s + 1);
    @(negedge clk);
    if (sel_in) model_b = model;
    else        model_a = model[1:0];
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    check("start_err_clear", obs_err, 0);
    check("start_fail_clear", 32'(obs_fail), 0);
    check("start_ff_clear", obs_ff, 0);
    for (int c = 0; c <= total; c++) begin
      if (c > 0) @(negedge clk);
      if (c == pulse_at)          drive_start(1'b1);
      else if (c == pulse_at + 1) drive_start(1'b0);
      exp_vec = (c < total) ? c / (s + 1) : n - 1;
      check("dut_i_sched", obs_dut_i, 32'(exp_vec));
      check("busy_sched", 32'(obs_busy), 32'(c < total));
      check("done_sched", 32'(obs_done), 32'(c >= total));
    end
    drive_start(1'b0);
    check("final_pass", 32'(obs_pass), 32'(exp_err == 0));
    check("final_fail", 32'(obs_fail), 32'(exp_err != 0));
    check("final_err_cnt", obs_err, 32'(exp_err));
    check("final_first_fail", obs_ff, 32'(exp_err != 0 ? exp_ff : 0));
  endtask

  typedef struct {
    bit         sel;
    logic [3:0] model;
    int         exp_err;
    int         exp_ff;
    int         pulse_at;
  } vec_t;

  vec_t tbl[7];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dut_i"}, obs_dut_i, 0);
    check({tag, "_busy"}, 32'(obs_busy), 0);
    check({tag, "_done"}, 32'(obs_done), 0);
    check({tag, "_pass"}, 32'(obs_pass), 0);
    check({tag, "_fail"}, 32'(obs_fail), 0);
    check({tag, "_err_cnt"}, obs_err, 0);
    check({tag, "_first_fail"}, obs_ff, 0);
  endtask

  initial begin
    int e, f;
    logic [3:0] m;
    bit s_r;

    tbl[0] = '{1'b0, 4'b0001, 0, 0, -1};  // inverter, pass
    tbl[1] = '{1'b0, 4'b0010, 2, 0, -1};  // buffer
    tbl[2] = '{1'b0, 4'b0011, 1, 1, -1};  // stuck at 1
    tbl[3] = '{1'b1, 4'b1000, 0, 0, -1};  // AND, pass
    tbl[4] = '{1'b1, 4'b1110, 2, 1, -1};  // OR
    tbl[5] = '{1'b1, 4'b1000, 0, 0, -1};  // restart from failing DONE
    tbl[6] = '{1'b0, 4'b0001, 0, 0,  1};  // extra start during WAIT

    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    model_a = 2'b01;
    model_b = 4'b1000;
    sel   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1; check_reset_outputs("rst_a");
    sel = 1'b1; #1; check_reset_outputs("rst_b");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i].sel, tbl[i].model, tbl[i].exp_err, tbl[i].exp_ff, tbl[i].pulse_at);
    end

    // Reset in the middle of the second vector's WAIT. The buffer model has already
    // produced one error at this point.
    sel = 1'b0;
    @(negedge clk);
    model_a = 2'b10;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    repeat (6) @(negedge clk);
    check("pre_rst_err_cnt", obs_err, 1);
    check("pre_rst_dut_i", obs_dut_i, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'(obs_busy), 0);
    run_vec(1'b0, 4'b0001, 0, 0, -1);

    // Random DUT tables, scored against the reference model.
    for (int r = 0; r < 10; r++) begin
      s_r = 1'($urandom_range(0, 1));
      m   = 4'($urandom);
      if (s_r) ref_model({12'h0, m}, 16'h0008, 4, e, f);
      else     ref_model({14'h0, m[1:0]}, 16'h0001, 2, e, f);
      run_vec(s_r, m, e, f, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_stim_checker.md
# lut_stim_checker

Synthesizable stimulus/response stage for the pp3 feature install tests. It sits directly upstream and downstream of a LUT design under test. It drives every input vector of a small LUT onto the DUT input and waits a programmable settle time. It then samples the DUT output, compares it with an expected truth table, and reports pass/fail, an error count and the first failing vector. On hardware it replaces the timed `#` delays and assertions that the simulation bench uses.

## Interface
- `WIDTH`, default 1: number of DUT inputs; there are N = 2**WIDTH vectors. Legal range is 1..4.
- `TRUTH`, default 2'b01: expected DUT output. Bit v is the expected output for input vector v. The default is an inverter. Width is N bits.
- `SETTLE`, default 4: wait cycles per vector before sampling. Must be ≥1.
- `clk` input 1: the single clock. All state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: single-cycle request. Accepted only in IDLE or DONE.
- `dut_i` output WIDTH: stimulus to the DUT input. Registered.
- `dut_o` input 1: DUT output. Sampled directly, with no synchronizer. SETTLE must cover the DUT path delay.
- `busy` output 1: high in WAIT and CHECK.
- `done` output 1: high in DONE.
- `pass` output 1: done and err_cnt==0.
- `fail` output 1: done and err_cnt!=0.
- `err_cnt` output WIDTH+1: number of mismatching vectors in the last run.
- `first_fail` output WIDTH: index of the first mismatching vector. Valid only while fail=1; otherwise 0.

## Operation
- Reset (rst_n=0 at an edge) forces the following, regardless of current state or start:
  - state=IDLE
  - dut_i=0, err_cnt=0, first_fail=0
  - busy=done=pass=fail=0
- States and transitions:
  - IDLE: on start, go to WAIT. Set vec=0, dut_i=0, cnt=SETTLE-1, err_cnt=0, first_fail=0.
  - WAIT: if cnt==0, go to CHECK; else decrement cnt. dut_i is held.
  - CHECK: compare dut_o with TRUTH[vec].
    - On mismatch: err_cnt increments. If this is the first mismatch of the run, first_fail=vec.
    - If vec==N-1: go to DONE.
    - Otherwise: vec and dut_i become vec+1, cnt=SETTLE-1, go to WAIT.
  - DONE: all results are held. start restarts the run exactly as from IDLE, clearing the results.
- start in WAIT or CHECK is ignored. There is no queuing.
- err_cnt cannot overflow, since its maximum is N and it is WIDTH+1 bits wide.
- vec never wraps; the DONE transition precedes any wrap.
- dut_i stays at N-1 in DONE. It returns to 0 only on reset or restart.

## Timing
- start is sampled at edge k. dut_i=0 is visible after edge k.
- Each vector takes SETTLE+1 cycles: SETTLE in WAIT and 1 in CHECK. dut_o for vector v is sampled at edge k + (v+1)(SETTLE+1).
- done, pass and fail rise after edge k + N(SETTLE+1). With the defaults this is k+10.
- err_cnt updates at the CHECK edge. It is visible the following cycle.
- Restart from DONE:
  - done, pass and fail drop after the accepting edge.
  - err_cnt and first_fail clear at that same edge.

## Structure
- Package `lut_stim_checker_pkg` holds:
  - state enum: IDLE, WAIT, CHECK, DONE
  - the WIDTH limit constant
- One sub-module, `settle_timer`: a loadable down-counter of width clog2(SETTLE). It has inputs load and dec and output zero. The FSM and result registers form the top-level block.
- Expected size is about 150–250 lines of RTL.

## Test plan
- Defaults with an inverter DUT model; pulse start at edge 0:
  - dut_i goes 0 then 1.
  - done=1 after edge 10, pass=1, err_cnt=0.
- Defaults with a buffer DUT model (dut_o=dut_i): fail=1, err_cnt=2, first_fail=0.
- Defaults with dut_o stuck at 1: fail=1, err_cnt=1, first_fail=1.
- WIDTH=2, TRUTH=4'b1000, SETTLE=2, DUT modelled as an AND gate:
  - dut_i steps 0,1,2,3, changing every 3 cycles.
  - pass after 12 cycles.
  - Repeat with an OR model: err_cnt=2, first_fail=1.
- Disturbed runs:
  - Pulse start again during WAIT: the run is unaffected.
  - Drive rst_n=0 for 1 cycle in the middle of the second vector's WAIT: all outputs return to their reset values on the next edge.
  - A subsequent start gives a full, correct run.
- Restart from DONE after a failing run with a correct model:
  - fail clears at the accepting edge.
  - The new run ends with pass=1.
